johnson_pwm_decoder: RTL and testbench
======================================

# johnson_pwm_decoder

Consumes the 8-bit Johnson-counter state and turns it into a 16-step PWM waveform. Duty is programmable in sixteenths through a valid/ready load port and double-buffered so updates apply only at a period boundary. Also reports the decoded phase, a per-period wrap strobe, a wrap count and a sticky illegal-code error. Sits directly downstream of the Johnson counter, inside the same tile.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single clock, shared with the Johnson counter.
- `rst_n` in 1: asynchronous reset, active-high (level 1 resets; port name kept for pin compatibility).
- `jc_in` in 8: Johnson counter state.
- `duty_in` in 5: requested duty in sixteenths, 0..16; values 17..31 clamp to 16.
- `duty_valid` in 1: `duty_in` offered.
- `duty_ready` out 1: block can accept a duty value.
- `pwm_out` out 1: PWM output.
- `phase` out 4: decoded phase of the last legal sample.
- `wrap` out 1: one-cycle strobe on a 15→0 phase transition.
- `wrap_cnt` out 8: count of wraps, modulo 256.
- `err` out 1: sticky flag; an illegal `jc_in` code has been seen.

## Operation
- Legal codes:
  - Phase 0 = 8'h00.
  - Phases 1..8 = 8'h80, C0, E0, F0, F8, FC, FE, FF.
  - Phases 9..15 = 8'h7F, 3F, 1F, 0F, 07, 03, 01.
  - Any other code is illegal.
- Every clock the block samples `jc_in` and decodes the sample.
- **Legal sample:**
  - `phase` takes the decoded value.
  - `pwm_out` = (decoded phase < active duty).
  - Duty 0 → always low; duty 16 → always high.
- **Illegal sample:**
  - `pwm_out` is forced to 0.
  - `phase` holds its value.
  - `err` sets and stays set until reset.
  - The wrap-tracking "previous legal" flag clears.
- **Wrap:**
  - A wrap is a legal decode of 0 whose immediately preceding sample was legal with phase 15.
  - On a wrap, `wrap` pulses for one cycle and `wrap_cnt` increments; 255 rolls over to 0.
  - Phase 0 repeated, or phase 0 reached from any other phase, is not a wrap.
- **Duty buffering:** a pending register (value plus valid bit) sits in front of the active duty register.
  - `duty_ready` = NOT pending_valid.
  - A handshake completes on a rising edge where `duty_valid` and `duty_ready` are both 1. The clamped value is then stored as pending.
- **At a wrap edge:**
  - If pending is valid: active ← pending, and pending_valid clears.
  - Else, if a handshake completes on the same edge: active ← the clamped `duty_in` directly, and pending stays empty.
  - Else: active is unchanged.
- The new active duty governs `pwm_out` from the phase-0 sample onward. The wrap sample itself is compared against the new duty.
- **Phase skips** (e.g. 3→5) are not errors. The decoded phase is used as-is.

## Timing
- Reset values:
  - `pwm_out` = 0, `phase` = 0, `wrap` = 0, `wrap_cnt` = 0, `err` = 0, `duty_ready` = 1.
  - Active duty = 0, pending empty, previous-legal flag clear.
- Reset is asserted asynchronously, mid-period included. All state clears immediately, and any accepted-but-unapplied duty is discarded.
- Latency: `jc_in` sampled at edge N → `pwm_out`, `phase`, `wrap`, `wrap_cnt` and `err` reflect it after edge N, i.e. 1 cycle. `wrap_cnt` shows the incremented value in the same cycle that `wrap` is high.
- `duty_ready` falls the cycle after an accepted handshake. It rises the cycle after the wrap that consumes the pending value.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `JPWM_SYNC_EN`.
- **Defined:**
  - `jc_in` passes through a 2-flop synchronizer (reset to 8'h00) before sampling.
  - Input-to-output latency becomes 3 cycles.
  - The synchronizer flops add no illegal-code filtering.
- **Undefined:** `jc_in` is sampled directly, with 1-cycle latency. For use when the counter shares `clk`.

## Test plan
- Reset, then drive the legal 16-code sequence once per clock with duty 0 → `pwm_out` always 0; `phase` = 0..15 one cycle late; `wrap` pulses once per 16 cycles; `wrap_cnt` increments.
- Load duty 5 mid-period, then keep cycling → `pwm_out` unchanged until the wrap. From the wrap onward, high for phases 0..4 and low for 5..15. `duty_ready` low from the accept until 1 cycle after the wrap.
- Load duty 20 → clamped to 16, `pwm_out` constant 1. Load duty 0 → constant 0.
- Handshake with duty 8 on the same edge as a wrap while pending is empty → duty 8 takes effect at that wrap, and `duty_ready` stays 1.
- Inject 8'h5A at phase 7 → `pwm_out` = 0 that cycle, `phase` holds 7, `err` = 1 and stays set. Following phase 0 after phase 15 still wraps normally, but 8'h5A followed by 8'h00 does not wrap.
- Assert reset during pending duty 12 → all outputs return to reset values and duty 12 is never applied. With `JPWM_SYNC_EN`, repeat the first scenario and check 3-cycle latency.

Source files
------------

// File: rtl/johnson_pwm_decoder.sv
// Johnson-counter state to 16-step PWM, with a double-buffered duty and phase/wrap/error reporting.
// Ports: clk, rst_n (async active-high), jc_in, duty_in/duty_valid/duty_ready, pwm_out, phase, wrap, wrap_cnt, err; option JPWM_SYNC_EN.
module johnson_pwm_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] jc_in,
  input  logic [4:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       pwm_out,
  output logic [3:0] phase,
  output logic       wrap,
  output logic [7:0] wrap_cnt,
  output logic       err
);

  logic [7:0] smp;

`ifdef JPWM_SYNC_EN
  logic [7:0] sync1;
  logic [7:0] sync2;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= jc_in;
      sync2 <= sync1;
    end
  end

  assign smp = sync2;
`else
  assign smp = jc_in;
`endif

  logic       legal;
  logic [3:0] dph;

  always_comb begin
    legal = 1'b1;
    dph   = 4'd0;
    case (smp)
      8'h00:   dph = 4'd0;
      8'h80:   dph = 4'd1;
      8'hC0:   dph = 4'd2;
      8'hE0:   dph = 4'd3;
      8'hF0:   dph = 4'd4;
      8'hF8:   dph = 4'd5;
      8'hFC:   dph = 4'd6;
      8'hFE:   dph = 4'd7;
      8'hFF:   dph = 4'd8;
      8'h7F:   dph = 4'd9;
      8'h3F:   dph = 4'd10;
      8'h1F:   dph = 4'd11;
      8'h0F:   dph = 4'd12;
      8'h07:   dph = 4'd13;
      8'h03:   dph = 4'd14;
      8'h01:   dph = 4'd15;
      default: legal = 1'b0;
    endcase
  end

  logic [4:0] active;
  logic [4:0] pend;
  logic       pend_v;
  logic       prev_legal;
  logic       hs;
  logic [4:0] clamp;
  logic       wrap_now;
  logic [4:0] act_nxt;

  assign duty_ready = ~pend_v;
  assign hs         = duty_valid & ~pend_v;
  assign clamp      = (duty_in > 5'd16) ? 5'd16 : duty_in;

  // phase holds the last legal decode, so with prev_legal set it is the
  // previous sample's phase.
  assign wrap_now = legal & (dph == 4'd0) & prev_legal & (phase == 4'd15);

  // The wrap sample is already compared against the incoming duty.
  always_comb begin
    act_nxt = active;
    if (wrap_now) begin
      if (pend_v)  act_nxt = pend;
      else if (hs) act_nxt = clamp;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      active     <= 5'd0;
      pend       <= 5'd0;
      pend_v     <= 1'b0;
      prev_legal <= 1'b0;
      pwm_out    <= 1'b0;
      phase      <= 4'd0;
      wrap       <= 1'b0;
      wrap_cnt   <= 8'd0;
      err        <= 1'b0;
    end else begin
      active     <= act_nxt;
      prev_legal <= legal;
      wrap       <= wrap_now;
      if (wrap_now) begin
        wrap_cnt <= wrap_cnt + 8'd1;
        pend_v   <= 1'b0;
      end else if (hs) begin
        pend     <= clamp;
        pend_v   <= 1'b1;
      end
      if (legal) begin
        phase   <= dph;
        pwm_out <= ({1'b0, dph} < act_nxt);
      end else begin
        pwm_out <= 1'b0;
        err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_johnson_pwm_decoder.sv
// Self-checking bench for johnson_pwm_decoder.
// Table vectors, hand sequences and a random run against a reference model.
module tb_johnson_pwm_decoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] jc_in;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic [3:0] phase;
  logic       wrap;
  logic [7:0] wrap_cnt;
  logic       err;

  johnson_pwm_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jc_in      (jc_in),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .phase      (phase),
    .wrap       (wrap),
    .wrap_cnt   (wrap_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] codes [16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8,
                             8'hFC, 8'hFE, 8'hFF, 8'h7F, 8'h3F, 8'h1F,
                             8'h0F, 8'h07, 8'h03, 8'h01};

  // reference model state
  int         m_phase;
  bit         m_prev;
  int         m_active;
  int         m_pend;
  bit         m_pendv;
  bit         m_err;
  int         m_wcnt;
  bit         m_pwm;
  bit         m_wrap;
  logic [7:0] m_pipe [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_prev   = 0;
    m_active = 0;
    m_pend   = 0;
    m_pendv  = 0;
    m_err    = 0;
    m_wcnt   = 0;
    m_pwm    = 0;
    m_wrap   = 0;
    m_pipe   = {};
`ifdef JPWM_SYNC_EN
    m_pipe.push_back(8'h00);
    m_pipe.push_back(8'h00);
`endif
  endtask

  task automatic model_edge(input logic [7:0] jc, input bit dv,
                            input int din);
    logic [7:0] s;
    int  idx;
    bit  hs;
    int  cl;
    bit  w;
    m_pipe.push_back(jc);
    s   = m_pipe.pop_front();
    idx = -1;
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) idx = i;
    hs = dv && !m_pendv;
    cl = (din > 16) ? 16 : din;
    w  = (idx == 0) && m_prev && (m_phase == 15);
    if (w) begin
      if (m_pendv) begin
        m_active = m_pend;
        m_pendv  = 0;
      end else if (hs) begin
        m_active = cl;
      end
      m_wcnt = (m_wcnt + 1) % 256;
    end else if (hs) begin
      m_pend  = cl;
      m_pendv = 1;
    end
    if (idx >= 0) begin
      m_phase = idx;
      m_pwm   = idx < m_active;
    end else begin
      m_pwm = 0;
      m_err = 1;
    end
    m_prev = (idx >= 0);
    m_wrap = w;
  endtask

  task automatic model_check();
    chk("m_pwm", pwm_out, m_pwm);
    chk("m_phase", phase, m_phase);
    chk("m_wrap", wrap, m_wrap);
    chk("m_wcnt", wrap_cnt, m_wcnt);
    chk("m_err", err, m_err);
    chk("m_rdy", duty_ready, !m_pendv);
  endtask

  task automatic step(input logic [7:0] jc, input bit dv, input int din);
    jc_in      = jc;
    duty_valid = dv;
    duty_in    = din[4:0];
    @(posedge clk);
    #1;
    model_edge(jc, dv, din);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    jc_in = 8'h00;
    duty_valid = 1'b0;
    duty_in = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] jc;
    logic       dv;
    logic [4:0] din;
    logic       pwm;
    logic [3:0] ph;
    logic       wr;
    logic [7:0] wc;
    logic       er;
    logic       rdy;
  } vec_t;

  vec_t vt [20];

  initial begin
    logic [7:0] jc;
    int p;
    int r;

    vt[0]  = '{8'h00, 1'b0, 5'd0,  1'b0, 4'd0,  1'b0, 8'd0, 1'b0, 1'b1};
    vt[1]  = '{8'h80, 1'b0, 5'd0,  1'b0, 4'd1,  1'b0, 8'd0, 1'b0, 1'b1};
    vt[2]  = '{8'hC0, 1'b1, 5'd5,  1'b0, 4'd2,  1'b0, 8'd0, 1'b0, 1'b0};
    vt[3]  = '{8'hE0, 1'b0, 5'd0,  1'b0, 4'd3,  1'b0, 8'd0, 1'b0, 1'b0};
    vt[4]  = '{8'h01, 1'b0, 5'd0,  1'b0, 4'd15, 1'b0, 8'd0, 1'b0, 1'b0};
    vt[5]  = '{8'h00, 1'b0, 5'd0,  1'b1, 4'd0,  1'b1, 8'd1, 1'b0, 1'b1};
    vt[6]  = '{8'hF0, 1'b0, 5'd0,  1'b1, 4'd4,  1'b0, 8'd1, 1'b0, 1'b1};
    vt[7]  = '{8'hFE, 1'b0, 5'd0,  1'b0, 4'd7,  1'b0, 8'd1, 1'b0, 1'b1};
    vt[8]  = '{8'h5A, 1'b0, 5'd0,  1'b0, 4'd7,  1'b0, 8'd1, 1'b1, 1'b1};
    vt[9]  = '{8'h00, 1'b0, 5'd0,  1'b1, 4'd0,  1'b0, 8'd1, 1'b1, 1'b1};
    vt[10] = '{8'h01, 1'b1, 5'd20, 1'b0, 4'd15, 1'b0, 8'd1, 1'b1, 1'b0};
    vt[11] = '{8'h00, 1'b0, 5'd0,  1'b1, 4'd0,  1'b1, 8'd2, 1'b1, 1'b1};
    vt[12] = '{8'h01, 1'b0, 5'd0,  1'b1, 4'd15, 1'b0, 8'd2, 1'b1, 1'b1};
    vt[13] = '{8'h00, 1'b1, 5'd8,  1'b1, 4'd0,  1'b1, 8'd3, 1'b1, 1'b1};
    vt[14] = '{8'hFF, 1'b0, 5'd0,  1'b0, 4'd8,  1'b0, 8'd3, 1'b1, 1'b1};
    vt[15] = '{8'hFE, 1'b0, 5'd0,  1'b1, 4'd7,  1'b0, 8'd3, 1'b1, 1'b1};
    vt[16] = '{8'h00, 1'b0, 5'd0,  1'b1, 4'd0,  1'b0, 8'd3, 1'b1, 1'b1};
    vt[17] = '{8'h00, 1'b0, 5'd0,  1'b1, 4'd0,  1'b0, 8'd3, 1'b1, 1'b1};
    vt[18] = '{8'h01, 1'b1, 5'd0,  1'b0, 4'd15, 1'b0, 8'd3, 1'b1, 1'b0};
    vt[19] = '{8'h00, 1'b0, 5'd0,  1'b0, 4'd0,  1'b1, 8'd4, 1'b1, 1'b1};

    do_reset();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_phase", phase, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_wcnt", wrap_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", duty_ready, 1);

`ifdef JPWM_SYNC_EN
    // three-register latency: phase 1 shows after the third edge
    step(8'h80, 0, 0);
    chk("lat1_phase", phase, 0);
    step(8'hC0, 0, 0);
    chk("lat2_phase", phase, 0);
    step(8'hE0, 0, 0);
    chk("lat3_phase", phase, 1);
    for (int k = 4; k < 40; k++) step(codes[k % 16], 0, 0);
`else
    for (int i = 0; i < 20; i++) begin
      step(vt[i].jc, vt[i].dv, int'(vt[i].din));
      chk($sformatf("tv%0d_pwm", i), pwm_out, vt[i].pwm);
      chk($sformatf("tv%0d_phase", i), phase, vt[i].ph);
      chk($sformatf("tv%0d_wrap", i), wrap, vt[i].wr);
      chk($sformatf("tv%0d_wcnt", i), wrap_cnt, vt[i].wc);
      chk($sformatf("tv%0d_err", i), err, vt[i].er);
      chk($sformatf("tv%0d_rdy", i), duty_ready, vt[i].rdy);
    end
`endif

    // async reset while duty 12 is pending: discarded, never applied
    do_reset();
    for (int k = 0; k < 8; k++) step(codes[k], 0, 0);
    step(codes[8], 1, 12);
    step(codes[9], 0, 0);
    chk("pend_rdy", duty_ready, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_phase", phase, 0);
    chk("arst_wcnt", wrap_cnt, 0);
    chk("arst_err", err, 0);
    chk("arst_rdy", duty_ready, 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      step(codes[k % 16], 0, 0);
      chk("nodut12_pwm", pwm_out, 0);
    end

    // clean periods long enough to roll wrap_cnt over
    do_reset();
    for (int k = 0; k < 16 * 260; k++) begin
      if (k % 160 == 3) step(codes[k % 16], 1, $urandom_range(0, 31));
      else step(codes[k % 16], 0, 0);
    end

    // randomized traffic: skips, illegal codes, duty loads
    p = 0;
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        jc = 8'($urandom);
      end else begin
        if (r < 6) p = $urandom_range(0, 15);
        else p = (p + 1) % 16;
        jc = codes[p];
      end
      step(jc, $urandom_range(0, 3) == 0, $urandom_range(0, 31));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
